imp_ctrl: RTL and testbench

IMP_CTRL -- requirements
Module: imp_ctrl

---
 rtl/imp_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_imp_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imp_ctrl.sv
// AXI-Lite register block that launches one image-processor job at a time and tracks its completion.
// Defining IMP_CTRL_PERF_EN adds a saturating job-length counter behind the CYCLES register.
module imp_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    output logic [1:0]  mem_axi_bresp,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic [1:0]  mem_axi_rresp,
    output logic [7:0]  imp_hsize,
    output logic [7:0]  imp_coor_minx,
    output logic [7:0]  imp_vsize,
    output logic [7:0]  imp_coor_miny,
    output logic [7:0]  imp_adr_pitch,
    output logic [31:0] imp_src_baddr,
    output logic [31:0] imp_dst_baddr,
    output logic        imp_st,
    input  logic        imp_done,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
    // valid, once raised, holds with its payload until that edge.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        live_q;
    logic        aw_cap_q, w_cap_q;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        irq_en_q, done_q;
    logic [31:0] size_q, src_q, dst_q;
    logic [7:0]  pitch_q;
    logic [31:0] cycles_rd;
    logic [31:0] rd_word;
    logic        rd_in_win;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    logic       busy, wr_commit, wr_in_win, wr_err, wr_ok, start_wr, done_set, done_clr;
    logic [2:0] wr_idx;

    assign busy      = (state_q != ST_IDLE);
    assign wr_commit = aw_cap_q && w_cap_q;
    assign wr_in_win = (aw_addr_q[31:5] == BASE_ADDR[31:5]);
    assign wr_idx    = aw_addr_q[4:2];
    // Geometry and address registers are frozen while a job runs so the engine sees stable values.
    assign wr_err    = !wr_in_win || (busy && (wr_idx inside {3'd2, 3'd3, 3'd4, 3'd5}));
    assign wr_ok     = wr_commit && !wr_err;
    assign start_wr  = wr_ok && (wr_idx == 3'd0) && w_strb_q[0] && w_data_q[0];
    assign done_clr  = wr_ok && (wr_idx == 3'd1) && w_strb_q[0] && w_data_q[1];
    assign done_set  = (state_q == ST_BUSY) && imp_done;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_wr) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (imp_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign mem_axi_awready = live_q && !aw_cap_q && !mem_axi_bvalid;
    assign mem_axi_wready  = live_q && !w_cap_q && !mem_axi_bvalid;
    assign mem_axi_arready = live_q && !mem_axi_rvalid;

    assign rd_in_win = (mem_axi_araddr[31:5] == BASE_ADDR[31:5]);
    always_comb begin
        rd_word = '0;
        if (rd_in_win) begin
            case (mem_axi_araddr[4:2])
                3'd0:    rd_word = {30'd0, irq_en_q, 1'b0};
                3'd1:    rd_word = {30'd0, done_q, busy};
                3'd2:    rd_word = size_q;
                3'd3:    rd_word = src_q;
                3'd4:    rd_word = dst_q;
                3'd5:    rd_word = {24'd0, pitch_q};
                3'd6:    rd_word = cycles_rd;
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q         <= 1'b0;
            aw_cap_q       <= 1'b0;
            w_cap_q        <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            mem_axi_bvalid <= 1'b0;
            mem_axi_bresp  <= 2'b00;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= '0;
            mem_axi_rresp  <= 2'b00;
            irq_en_q       <= 1'b0;
            done_q         <= 1'b0;
            size_q         <= '0;
            src_q          <= '0;
            dst_q          <= '0;
            pitch_q        <= '0;
        end else begin
            live_q <= 1'b1;
            if (mem_axi_awvalid && mem_axi_awready) begin
                aw_cap_q  <= 1'b1;
                aw_addr_q <= mem_axi_awaddr;
            end
            if (mem_axi_wvalid && mem_axi_wready) begin
                w_cap_q  <= 1'b1;
                w_data_q <= mem_axi_wdata;
                w_strb_q <= mem_axi_wstrb;
            end
            if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;
            if (wr_commit) begin
                aw_cap_q       <= 1'b0;
                w_cap_q        <= 1'b0;
                mem_axi_bvalid <= 1'b1;
                mem_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
            end
            if (wr_ok) begin
                case (wr_idx)
                    3'd0:    if (w_strb_q[0]) irq_en_q <= w_data_q[1];
                    3'd2:    size_q <= merge_bytes(size_q, w_data_q, w_strb_q);
                    3'd3:    src_q  <= merge_bytes(src_q, w_data_q, w_strb_q);
                    3'd4:    dst_q  <= merge_bytes(dst_q, w_data_q, w_strb_q);
                    3'd5:    if (w_strb_q[0]) pitch_q <= w_data_q[7:0];
                    default: ;
                endcase
            end
            // A completion in the same cycle as a clear must not be lost.
            if (done_set)      done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
            if (mem_axi_arvalid && mem_axi_arready) begin
                mem_axi_rvalid <= 1'b1;
                mem_axi_rdata  <= rd_word;
                mem_axi_rresp  <= rd_in_win ? 2'b00 : 2'b10;
            end else if (mem_axi_rvalid && mem_axi_rready) begin
                mem_axi_rvalid <= 1'b0;
            end
        end
    end

`ifdef IMP_CTRL_PERF_EN
    logic [31:0] cycles_q;
    always_ff @(posedge clk) begin
        if (rst)                                             cycles_q <= '0;
        else if (state_q == ST_IDLE && state_d == ST_START)  cycles_q <= '0;
        else if (busy && cycles_q != 32'hFFFF_FFFF)          cycles_q <= cycles_q + 32'd1;
    end
    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = 32'd0;
`endif

    assign imp_hsize     = size_q[7:0];
    assign imp_coor_minx = size_q[15:8];
    assign imp_vsize     = size_q[23:16];
    assign imp_coor_miny = size_q[31:24];
    assign imp_adr_pitch = pitch_q;
    assign imp_src_baddr = src_q;
    assign imp_dst_baddr = dst_q;
    assign imp_st        = (state_q == ST_START);
    assign irq           = done_q & irq_en_q;
    assign dbg_state     = state_q;

    logic unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot, aw_addr_q[1:0], mem_axi_araddr[1:0]};

endmodule

// File: tb/tb_imp_ctrl.sv
// Directed-plus-random bench for imp_ctrl: AXI-Lite drivers, a register-map reference model
// and a job responder that answers imp_st with a timed imp_done pulse.
module tb_imp_ctrl;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [7:0]  hsize, minx, vsize, miny, pitch;
    logic [31:0] src_baddr, dst_baddr;
    logic        imp_st, imp_done, irq;
    logic [1:0]  dbg_state;
    logic        done_pulse = 1'b0, done_force = 1'b0;

    assign imp_done = done_pulse | done_force;

    always #5 clk = ~clk;

    imp_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
        .imp_hsize(hsize), .imp_coor_minx(minx), .imp_vsize(vsize), .imp_coor_miny(miny),
        .imp_adr_pitch(pitch), .imp_src_baddr(src_baddr), .imp_dst_baddr(dst_baddr),
        .imp_st(imp_st), .imp_done(imp_done), .irq(irq), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Responder: counts start pulses and fires imp_done done_delay cycles after a pulse.
    int st_count   = 0;
    int done_delay = -1;
    int cd         = -1;
    always @(negedge clk) begin
        done_pulse = 1'b0;
        if (imp_st) begin
            st_count++;
            cd = done_delay;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) done_pulse = 1'b1;
        end
    end

    // Reference model of the register file.
    logic [31:0] m_size = '0, m_src = '0, m_dst = '0, m_cycles = '0;
    logic [7:0]  m_pitch = '0;
    logic        m_irq_en = 1'b0, m_done = 1'b0;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = strb_mask(s);
        case (idx)
            0: if (s[0]) m_irq_en = d[1];
            1: if (s[0] && d[1]) m_done = 1'b0;
            2: m_size = (m_size & ~m) | (d & m);
            3: m_src  = (m_src & ~m) | (d & m);
            4: m_dst  = (m_dst & ~m) | (d & m);
            5: if (s[0]) m_pitch = d[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read_idle(input int idx);
        case (idx)
            0: return m_irq_en ? 32'h2 : 32'h0;
            1: return m_done ? 32'h2 : 32'h0;
            2: return m_size;
            3: return m_src;
            4: return m_dst;
            5: return {24'd0, m_pitch};
            6: return m_cycles;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; resp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if (cyc > 200) begin
                awvalid = 1'b0; wvalid = 1'b0;
                timeout_fail("write_addr_data");
                return;
            end
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bvalid) begin
            timeout_fail("write_resp");
            return;
        end
        repeat (b_dly) @(negedge clk);
        bready = 1'b1;
        resp = bresp;
        @(posedge clk);
        #1 bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        cyc = 0; data = 'x; resp = 2'bxx;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (!arready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!arready) begin
            arvalid = 1'b0;
            timeout_fail("read_addr");
            return;
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!rvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!rvalid) begin
            timeout_fail("read_data");
            return;
        end
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(BASE + 32'(idx * 4), d, r);
        check({tag, "_rresp"}, {30'd0, r}, 32'h0);
        check({tag, "_rdata"}, d, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_geom"}, {miny, vsize, minx, hsize}, m_size);
        check({tag, "_src"}, src_baddr, m_src);
        check({tag, "_dst"}, dst_baddr, m_dst);
        check({tag, "_pitch"}, {24'd0, pitch}, {24'd0, m_pitch});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_done & m_irq_en});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d, data;
        logic [3:0]  strb;
        int          idx, cyc;
        bit          outside;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'h0);
        check("rst_wready", {31'd0, wready}, 32'h0);
        check("rst_arready", {31'd0, arready}, 32'h0);
        check("rst_bvalid", {31'd0, bvalid}, 32'h0);
        check("rst_rvalid", {31'd0, rvalid}, 32'h0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_imp_st", {31'd0, imp_st}, 32'h0);
        check("rst_state", {30'd0, dbg_state}, 32'h0);
        check_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {29'd0, awready, wready, arready}, 32'h7);

        // SIZE write with AW leading W by two cycles
        axi_write(BASE + 32'h8, 32'h0006_0004, 4'hF, 0, 2, 0, resp);
        model_write(2, 32'h0006_0004, 4'hF);
        check("size_bresp", {30'd0, resp}, 32'h0);
        @(negedge clk);
        check("size_hsize", {24'd0, hsize}, 32'd4);
        check("size_vsize", {24'd0, vsize}, 32'd6);
        check_reg("size_rb", 2, 32'h0006_0004);

        // Random register traffic while idle
        for (int i = 0; i < 24; i++) begin
            idx     = $urandom_range(0, 7);
            d       = $urandom;
            strb    = 4'($urandom_range(0, 15));
            outside = ($urandom_range(0, 5) == 0);
            if (idx == 0) d[0] = 1'b0;
            axi_write(outside ? (BASE + 32'h20 + 32'(idx * 4)) : (BASE + 32'(idx * 4)), d, strb,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
            if (!outside) model_write(idx, d, strb);
            check("rand_bresp", {30'd0, resp}, outside ? 32'h2 : 32'h0);
            idx = $urandom_range(0, 7);
            check_reg("rand_rb", idx, exp_read_idle(idx));
            check_outputs("rand");
        end
        axi_read(BASE - 32'h4, data, resp);
        check("below_win_rresp", {30'd0, resp}, 32'h2);
        check("below_win_rdata", data, 32'h0);

        // Job with completion 10 cycles after the start pulse
        st_count = 0; done_delay = 10;
        axi_write(BASE, 32'h3, 4'hF, 0, 0, 0, resp);
        model_write(0, 32'h3, 4'hF);
        check("job1_bresp", {30'd0, resp}, 32'h0);
        check_reg("job1_status_busy", 1, 32'h1);
        repeat (20) @(negedge clk);
        m_done = 1'b1;
        m_cycles = 32'd0;
`ifdef IMP_CTRL_PERF_EN
        m_cycles = 32'd11;
`endif
        check("job1_pulses", 32'(st_count), 32'd1);
        check_reg("job1_status_done", 1, 32'h2);
        check("job1_irq", {31'd0, irq}, 32'h1);
        check_reg("job1_cycles", 6, m_cycles);

        // imp_done while idle is ignored
        done_force = 1'b1;
        repeat (3) @(negedge clk);
        done_force = 1'b0;
        check("idle_done_state", {30'd0, dbg_state}, 32'h0);
        check_reg("idle_done_status", 1, 32'h2);

        // Writes while busy: geometry/address rejected, second START ignored
        st_count = 0; done_delay = 40;
        axi_write(BASE, 32'h3, 4'hF, 0, 0, 0, resp);
        check("job2_bresp", {30'd0, resp}, 32'h0);
        axi_write(BASE + 32'hC, 32'h100, 4'hF, 1, 0, 0, resp);
        check("busy_src_bresp", {30'd0, resp}, 32'h2);
        axi_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, resp);
        check("busy_size_bresp", {30'd0, resp}, 32'h2);
        check("busy_geom_stable", {miny, vsize, minx, hsize}, m_size);
        axi_write(BASE, 32'h3, 4'hF, 0, 0, 0, resp);
        check("busy_start_bresp", {30'd0, resp}, 32'h0);
        check_reg("busy_src_rb", 3, m_src);
        repeat (50) @(negedge clk);
        check("job2_pulses", 32'(st_count), 32'd1);
`ifdef IMP_CTRL_PERF_EN
        m_cycles = 32'd41;
`endif
        check_reg("job2_cycles", 6, m_cycles);
        check_outputs("job2");

        // DONE clear needs strobe byte 0
        axi_write(BASE + 32'h4, 32'h2, 4'hE, 0, 0, 0, resp);
        check_reg("w1c_nostrb", 1, 32'h2);
        axi_write(BASE + 32'h4, 32'h2, 4'hF, 0, 0, 1, resp);
        m_done = 1'b0;
        check_reg("w1c_clear", 1, 32'h0);
        check("w1c_irq", {31'd0, irq}, 32'h0);

        // DONE clear colliding with job completion: the set wins
        st_count = 0; done_delay = -1;
        axi_write(BASE, 32'h3, 4'hF, 0, 0, 0, resp);
        repeat (2) @(negedge clk);
        @(negedge clk);
        awaddr = BASE + 32'h4; awvalid = 1'b1;
        wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        check("race_ready", {30'd0, awready, wready}, 32'h3);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bvalid) timeout_fail("race_bresp");
        else check("race_bresp", {30'd0, bresp}, 32'h0);
        @(posedge clk);
        #1 bready = 1'b0;
        m_done = 1'b1;
        check_reg("race_status", 1, 32'h2);
        check("race_irq", {31'd0, irq}, 32'h1);
        check("race_pulses", 32'(st_count), 32'd1);

        // Out-of-window read held with rready low
        @(negedge clk);
        araddr = BASE + 32'h40; arvalid = 1'b1; rready = 1'b0;
        cyc = 0;
        while (!arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("oow_hold_rvalid", {31'd0, rvalid}, 32'h1);
            check("oow_hold_rdata", rdata, 32'h0);
            check("oow_hold_rresp", {30'd0, rresp}, 32'h2);
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        @(negedge clk);
        check("oow_rvalid_drop", {31'd0, rvalid}, 32'h0);

        // Reset in the middle of a job, then a late imp_done
        st_count = 0; done_delay = -1;
        axi_write(BASE, 32'h3, 4'hF, 0, 0, 0, resp);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_force = 1'b1;
        repeat (4) @(negedge clk);
        done_force = 1'b0;
        m_size = '0; m_src = '0; m_dst = '0; m_pitch = '0;
        m_irq_en = 1'b0; m_done = 1'b0; m_cycles = '0;
        check("abort_state", {30'd0, dbg_state}, 32'h0);
        check("abort_pulses", 32'(st_count), 32'd1);
        check_outputs("abort");
        for (int i = 0; i < 8; i++) check_reg("abort_reg", i, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
